// File: rtl/ps2_key_source.sv
// PS/2 set-2 keyboard receiver: frames the serial bits, decodes make codes and
// queues them in a show-ahead FIFO that feeds the MMU key interface.
`timescale 1ns/1ps
module ps2_key_source #(
  parameter int FIFO_AW = 3,
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       key_get,
  output logic       key_down,
  output logic [7:0] spec_key,
  output logic       overflow,
  output logic       frame_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TO_W  = $clog2(TIMEOUT) + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  // Synchroniser stage: pins are asynchronous and idle high
  logic clk_s0_q, clk_s1_q, clk_s2_q;
  logic dat_s0_q, dat_s1_q;
  logic key_get_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s0_q  <= 1'b1;
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      dat_s0_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      key_get_q <= 1'b0;
    end else begin
      clk_s0_q  <= ps2_clk;
      clk_s1_q  <= clk_s0_q;
      clk_s2_q  <= clk_s1_q;
      dat_s0_q  <= ps2_data;
      dat_s1_q  <= dat_s0_q;
      key_get_q <= key_get;
    end
  end

  logic fall;
  logic bit_in;
  assign fall   = clk_s2_q & ~clk_s1_q;
  assign bit_in = dat_s1_q;

  // Frame stage: start, 8 data bits LSB first, odd parity, stop
  state_t          state_q;
  logic [3:0]      cnt_q;
  logic [7:0]      shift_q;
  logic            par_q;
  logic [TO_W-1:0] to_q;
  logic            frame_err_q;
  logic            byte_valid;

  assign byte_valid = fall && (state_q == SHIFT) && (cnt_q == 4'd10) &&
                      bit_in && (^{shift_q, par_q});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      to_q        <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          to_q <= '0;
          if (fall) begin
            if (!bit_in) begin
              state_q <= SHIFT;
              cnt_q   <= 4'd1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (fall) begin
            to_q <= '0;
            if (cnt_q <= 4'd8) begin
              shift_q <= {bit_in, shift_q[7:1]};
              cnt_q   <= cnt_q + 4'd1;
            end else if (cnt_q == 4'd9) begin
              par_q <= bit_in;
              cnt_q <= 4'd10;
            end else begin
              state_q <= IDLE;
              cnt_q   <= 4'd0;
              if (!(bit_in && (^{shift_q, par_q}))) frame_err_q <= 1'b1;
            end
          end else if (to_q == TO_W'(TIMEOUT - 1)) begin
            // Keyboard stalled mid-frame: drop the partial byte
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            to_q        <= '0;
            frame_err_q <= 1'b1;
          end else begin
            to_q <= to_q + TO_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign frame_err = frame_err_q;

  // Decode and queue stage
  logic               brk_q, ext_q;
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               overflow_q;
  logic [7:0]         mem [DEPTH];

  logic is_f0, is_e0, push_req, pop, accept;
  assign is_f0    = (shift_q == 8'hF0);
  assign is_e0    = (shift_q == 8'hE0);
  assign push_req = byte_valid && !is_f0 && !is_e0 && !brk_q;
  assign pop      = key_get && !key_get_q && (count_q != '0);
  // A same-cycle pop frees the slot, so a full FIFO still accepts the push
  assign accept   = push_req && ((count_q != (FIFO_AW+1)'(DEPTH)) || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (byte_valid) begin
        if (is_f0) begin
          brk_q <= 1'b1;
        end else if (is_e0) begin
          ext_q <= 1'b1;
        end else begin
          brk_q <= 1'b0;
          ext_q <= 1'b0;
        end
      end
      if (accept) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      case ({accept, pop})
        2'b10:   count_q <= count_q + (FIFO_AW+1)'(1);
        2'b01:   count_q <= count_q - (FIFO_AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (push_req && !accept) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= shift_q;
  end

  assign key_down = (count_q != '0);
  assign spec_key = key_down ? mem[rd_ptr_q] : 8'h00;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_key_source.sv
// Directed bench for ps2_key_source: PS/2 frames in, scoreboard of expected
// make codes compared against the FIFO head as entries are popped.
`timescale 1ns/1ps
module tb_ps2_key_source;

  localparam int TO = 300;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk, ps2_data, key_get;
  logic       key_down, overflow, frame_err;
  logic [7:0] spec_key;

  int total = 0;
  int bad   = 0;
  int ferr_cnt = 0;
  int ferr_exp = 0;

  logic [7:0] exp_q[$];
  bit brk_m = 1'b0;
  bit ext_m = 1'b0;
  bit ovf_exp = 1'b0;

  ps2_key_source #(.FIFO_AW(3), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_get(key_get), .key_down(key_down), .spec_key(spec_key),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decoder for one received byte
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hF0) brk_m = 1'b1;
    else if (b == 8'hE0) ext_m = 1'b1;
    else if (brk_m) begin
      brk_m = 1'b0;
      ext_m = 1'b0;
    end else begin
      ext_m = 1'b0;
      if (exp_q.size() < 8) exp_q.push_back(b);
      else ovf_exp = 1'b1;
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(posedge clk); #1 ps2_data = b;
    repeat (4) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (4) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit pop_at, input bit lat);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1 ps2_data = bits[i];
      repeat (4) @(posedge clk);
      #1 ps2_clk = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        @(posedge clk); #1;
        if (i == 10 && pop_at && k == 2) key_get = 1'b1;
        if (i == 10 && lat && k == 2) chk("lat_before", key_down, 1'b0);
        if (i == 10 && lat && k == 3) chk("lat_after", key_down, 1'b1);
      end
      ps2_clk = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1 key_get = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send_ok(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b0);
    model_byte(b);
  endtask

  // Check the head, then hold key_get for 5 cycles: exactly one entry leaves
  task automatic pop_check(input string tag);
    chk({tag, "_kd"}, key_down, 1'b1);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_sb: observed=empty-scoreboard expected=entry", tag);
    end else begin
      chk({tag, "_key"}, spec_key, exp_q[0]);
      void'(exp_q.pop_front());
    end
    @(posedge clk); #1 key_get = 1'b1;
    repeat (5) @(posedge clk);
    #1 key_get = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain_check(input string tag);
    chk({tag, "_kd0"}, key_down, 1'b0);
    chk({tag, "_key0"}, spec_key, 8'h00);
    chk({tag, "_sb"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] fill [8];
    fill = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};
    ps2_clk = 1'b1; ps2_data = 1'b1; key_get = 1'b0; rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_kd", key_down, 1'b0);
    chk("rst_key", spec_key, 8'h00);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Single make code with latency check and held key_get
    send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
    model_byte(8'h1C);
    pop_check("make1c");
    drain_check("make1c");

    // Make / break / make
    send_ok(8'h1C); send_ok(8'hF0); send_ok(8'h1C);
    pop_check("brk");
    drain_check("brk");

    // Extended make
    send_ok(8'hE0); send_ok(8'h75);
    pop_check("ext");
    drain_check("ext");

    // Extended break, then a plain make proves the flags cleared
    send_ok(8'hE0); send_ok(8'hF0); send_ok(8'h75);
    drain_check("extbrk");
    send_ok(8'h1C);
    pop_check("after_extbrk");
    drain_check("after_extbrk");
    chk("ferr_clean", ferr_cnt, ferr_exp);

    // Parity error, then a stray clock with data high in IDLE
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    ferr_exp++;
    chk("par_ferr", ferr_cnt, ferr_exp);
    drain_check("par");
    ps2_bit(1'b1);
    repeat (4) @(posedge clk);
    #1;
    ferr_exp++;
    chk("start_ferr", ferr_cnt, ferr_exp);
    send_ok(8'h32);
    pop_check("after_par");
    drain_check("after_par");

    // Fill to depth, then a pop landing on the byte_valid cycle of a 9th code
    for (int i = 0; i < 8; i++) send_ok(fill[i]);
    chk("full_ovf0", overflow, 1'b0);
    chk("full_head", spec_key, 8'h16);
    send_frame(8'h46, 1'b0, 1'b1, 1'b0);
    void'(exp_q.pop_front());
    model_byte(8'h46);
    chk("samecyc_ovf", overflow, ovf_exp);
    chk("samecyc_head", spec_key, 8'h1E);
    // Still full: this one is dropped
    send_ok(8'h45);
    chk("drop_ovf", overflow, ovf_exp);
    for (int i = 0; i < 8; i++) pop_check("order");
    drain_check("order");
    chk("ovf_sticky", overflow, 1'b1);

    // Stall after 4 bits
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    repeat (TO + 20) @(posedge clk);
    #1;
    ferr_exp++;
    chk("timeout_ferr", ferr_cnt, ferr_exp);
    drain_check("timeout");
    send_ok(8'h29);
    pop_check("after_to");
    drain_check("after_to");

    // Reset with a queued code and a frame in flight
    send_ok(8'h1C);
    chk("pre_rst_kd", key_down, 1'b1);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    @(posedge clk); #1 ps2_data = 1'b0;
    repeat (2) @(posedge clk);
    #1 ps2_clk = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    brk_m = 1'b0; ext_m = 1'b0; ovf_exp = 1'b0;
    chk("mid_rst_kd", key_down, 1'b0);
    chk("mid_rst_key", spec_key, 8'h00);
    chk("mid_rst_ovf", overflow, 1'b0);
    chk("mid_rst_ferr", frame_err, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    send_ok(8'h4D);
    pop_check("after_rst");
    drain_check("after_rst");
    chk("final_ovf", overflow, ovf_exp);
    chk("final_ferr", ferr_cnt, ferr_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_source.md
Name: ps2_key_source

Overview:
Receives PS/2 keyboard frames and decodes set-2 scan codes into make-code events, which it queues in a small FIFO. It drives the keyboard side of the MMU key interface: key_down means a code is waiting, spec_key carries the head code, and key_get pops it. It sits between the board PS/2 pins and the MMU, and the CPU polls it at BFD0400C (status) and BFD04008 (data).

Parameters:
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW entries (default 8).
TIMEOUT, 50000, clk cycles with no ps2_clk falling edge before a partial frame is abandoned.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
ps2_clk  input  1  raw PS/2 clock from the pin, asynchronous
ps2_data  input  1  raw PS/2 data from the pin, asynchronous
key_get  input  1  pop request from the MMU; a level that may stay high for several cycles
key_down  output  1  FIFO not empty
spec_key  output  8  FIFO head scan code (show-ahead); 8'h00 when empty
overflow  output  1  sticky; set when a make code is dropped because the FIFO is full
frame_err  output  1  one-cycle pulse on a parity, start, stop or timeout error

Behaviour:
- Sync: ps2_clk and ps2_data each pass through 2 flops. A falling edge is the synced clk going 1 -> 0 (a third flop holds the previous value). Data is sampled on that same edge.
- Frame FSM, states IDLE and SHIFT, with a bit counter 0..10:
  - IDLE: on a falling edge with data=0 (start bit) -> SHIFT, cnt=1. A falling edge with data=1 -> frame_err pulse, stay in IDLE.
  - SHIFT, cnt 1..8: shift data bits in LSB first.
  - SHIFT, cnt 9: capture the parity bit.
  - SHIFT, cnt 10: check the stop bit (must be 1) and odd parity over data+parity. If OK, byte_valid pulses for 1 cycle on that edge's cycle. Otherwise frame_err pulses. Either way -> IDLE.
  - Timeout counter: cleared on every falling edge and in IDLE. When it reaches TIMEOUT-1 while in SHIFT -> IDLE, frame_err pulses, partial byte discarded.
- Decoder, flags brk and ext:
  - byte F0: set brk, push nothing.
  - byte E0: set ext, push nothing.
  - any other byte with brk=1: discard it, clear brk and ext (release event).
  - any other byte with brk=0: push the byte, clear ext. Extended makes push the raw second byte; the E0 is not queued.
  - Typematic repeats are pushed like any other make code.
- FIFO: circular, FIFO_AW-bit pointers plus a count of width FIFO_AW+1.
  - key_down = (count != 0).
  - spec_key = mem[rd_ptr] when non-empty, else 0.
- Pop: on the rising edge of key_get (key_get=1 and key_get_q=0) with the FIFO non-empty, advance rd_ptr by 1. A level held high pops exactly once. A rising edge while empty is ignored.
- Push: on a decoder push with count < depth. If full, the byte is dropped, overflow is set, and FIFO contents are unchanged.
- Push and pop in the same cycle: both happen and count is unchanged. When full, a same-cycle pop frees the slot and the push is accepted with no overflow.
- Pointers wrap modulo depth.
- Latency: key_down rises on the cycle after the byte_valid cycle, i.e. 1 clk after the stop-bit falling edge is detected (sync adds about 3 clk after the pin edge).
- Reset, synchronous:
  - FSM to IDLE; cnt, timeout counter, brk and ext cleared.
  - FIFO emptied.
  - Outputs: key_down=0, spec_key=0, overflow=0, frame_err=0.
  - Sync flops load 1 (the bus idle level), and key_get_q loads 0.
  - A frame in flight during reset is lost. Receiving resumes at the next start bit.

Test Plan:
- Send frame 1C (data bits 00111000 LSB first, parity 0, stop 1) -> key_down=1 and spec_key=8'h1C 1 clk after byte_valid. Hold key_get high 5 cycles -> exactly one pop, key_down=0, spec_key=0.
- Send 1C, F0, 1C -> exactly one entry (1C). Send E0, 75 -> one entry 75. Send E0, F0, 75 -> no entry, brk=0 and ext=0 afterwards.
- Send frame 1C with parity bit 1 -> frame_err pulses 1 cycle, FIFO stays empty. Then send a valid 32 -> accepted.
- Send 9 distinct make codes (depth 8) without popping -> codes 1..8 queued, 9th dropped, overflow=1. Pop all 8 -> order preserved.
- With FIFO full, time the key_get rising edge to land on the byte_valid cycle of a 10th code -> no overflow, count stays 8, new code is last.
- Send 4 bits then stop toggling ps2_clk for TIMEOUT cycles -> frame_err pulse, FSM back to IDLE. Then send full frame 29 -> spec_key=8'h29. Separately, assert rst mid-frame -> all outputs 0, next frame received correctly.
